// File: rtl/mem_stage.sv
// Memory-access stage of the RV32 pipeline: collects in-order DRAM read data, aligns loads, registers MEM->WB.
// Optional misaligned-load detection is compiled in with `define MEM_MISALIGN_CHECK_EN.

package mem_stage_pkg;
    localparam int XLEN         = 32;
    localparam int REG_AW       = 5;
    localparam int MEM_OP_WIDTH = 3;
    // One-hot access-size bit positions within mem_pipe_mem_opcode.
    localparam int OP_BYTE      = 0;
    localparam int OP_HALF      = 1;
    localparam int OP_WORD      = 2;
endpackage

module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_b,

    input  logic                    mem_pipe_valid,
    input  logic [XLEN-1:0]         mem_pipe_pc,
    input  logic [XLEN-1:0]         mem_pipe_instruction,
    input  logic [MEM_OP_WIDTH-1:0] mem_pipe_mem_opcode,
    input  logic                    mem_pipe_mem_read,
    input  logic                    mem_pipe_unsign,
    input  logic                    mem_pipe_rd_write,
    input  logic [REG_AW-1:0]       mem_pipe_rd_addr,
    input  logic [XLEN-1:0]         mem_pipe_alu_result,
    output logic                    mem_pipe_ready,
    output logic                    mem_pipe_flush,

    input  logic                    dram_data_ok,
    input  logic [XLEN-1:0]         dram_rdata,

    input  logic                    wb_pipe_ready,
    input  logic                    wb_pipe_flush,
    output logic                    wb_pipe_valid,
    output logic [XLEN-1:0]         wb_pipe_pc,
    output logic [XLEN-1:0]         wb_pipe_instruction,
    output logic                    wb_pipe_rd_write,
    output logic [REG_AW-1:0]       wb_pipe_rd_addr,
    output logic [XLEN-1:0]         wb_pipe_rd_wdata,
    output logic                    wb_pipe_exc_load_mis,

    output logic                    mem_rd_write,
    output logic [REG_AW-1:0]       mem_rd_addr,
    output logic [XLEN-1:0]         mem_rd_wdata,
    output logic                    mem_load_pending,

    output logic [1:0]              o_dbg_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [1:0]      r_drop_cnt;
    logic [XLEN-1:0] r_hold_data;

    logic            r_wb_valid;
    logic [XLEN-1:0] r_wb_pc;
    logic [XLEN-1:0] r_wb_instruction;
    logic            r_wb_rd_write;
    logic [REG_AW-1:0] r_wb_rd_addr;
    logic [XLEN-1:0] r_wb_rd_wdata;
    logic            r_wb_exc_load_mis;

    logic            w_mem_valid;
    logic            w_is_load;
    logic            w_data_ok;
    logic            w_mem_done;
    logic            w_capture;
    logic            w_drop_inc;
    logic            w_drop_dec;
    logic            w_misalign;
    logic [1:0]      w_addr_lo;
    logic [XLEN-1:0] w_load_word;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [XLEN-1:0] w_load_data;
    logic [XLEN-1:0] w_rd_wdata;

    assign w_mem_valid = mem_pipe_valid & ~wb_pipe_flush;
    assign w_is_load   = w_mem_valid & mem_pipe_mem_read;
    // Responses arriving while drop_cnt != 0 belong to flushed loads and are never consumed.
    assign w_data_ok   = dram_data_ok & (r_drop_cnt == 2'd0);
    assign w_addr_lo   = mem_pipe_alu_result[1:0];

    always_comb begin
        w_mem_done = 1'b1;
        if (mem_pipe_mem_read) begin
            w_mem_done = w_data_ok | (r_state == S_HOLD);
        end
    end

    assign mem_pipe_ready   = ~mem_pipe_valid | (wb_pipe_ready & w_mem_done);
    assign mem_pipe_flush   = wb_pipe_flush;
    assign mem_load_pending = w_is_load & ~w_mem_done;
    assign o_dbg_state      = r_state;

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A zero-wait response that WB cannot take yet must still be parked.
                if (w_is_load) begin
                    if (!w_data_ok) begin
                        w_state_nxt = S_WAIT;
                    end else if (!wb_pipe_ready) begin
                        w_state_nxt = S_HOLD;
                        w_capture   = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (wb_pipe_flush) begin
                    w_state_nxt = S_IDLE;
                end else if (w_data_ok) begin
                    if (wb_pipe_ready) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_HOLD;
                        w_capture   = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (wb_pipe_flush || wb_pipe_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // A flush in WAIT leaves one response outstanding unless it arrives in that same cycle.
    assign w_drop_inc = (r_state == S_WAIT) & wb_pipe_flush & ~w_data_ok;
    assign w_drop_dec = dram_data_ok & (r_drop_cnt != 2'd0);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state     <= S_IDLE;
            r_drop_cnt  <= 2'd0;
            r_hold_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_drop_inc && !w_drop_dec) begin
                r_drop_cnt <= r_drop_cnt + 2'd1;
            end else if (w_drop_dec && !w_drop_inc) begin
                r_drop_cnt <= r_drop_cnt - 2'd1;
            end
            if (w_capture) begin
                r_hold_data <= dram_rdata;
            end
        end
    end

    always_comb begin
        w_load_word = (r_state == S_HOLD) ? r_hold_data : dram_rdata;
        w_byte      = w_load_word[7:0];
        case (w_addr_lo)
            2'd0:    w_byte = w_load_word[7:0];
            2'd1:    w_byte = w_load_word[15:8];
            2'd2:    w_byte = w_load_word[23:16];
            default: w_byte = w_load_word[31:24];
        endcase
        w_half = w_addr_lo[1] ? w_load_word[31:16] : w_load_word[15:0];
        if (mem_pipe_mem_opcode[OP_BYTE]) begin
            w_load_data = {{24{~mem_pipe_unsign & w_byte[7]}}, w_byte};
        end else if (mem_pipe_mem_opcode[OP_HALF]) begin
            w_load_data = {{16{~mem_pipe_unsign & w_half[15]}}, w_half};
        end else begin
            w_load_data = w_load_word;
        end
    end

`ifdef MEM_MISALIGN_CHECK_EN
    assign w_misalign = mem_pipe_mem_read &
                        ((mem_pipe_mem_opcode[OP_HALF] & w_addr_lo[0]) |
                         (mem_pipe_mem_opcode[OP_WORD] & (w_addr_lo != 2'd0)));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_rd_wdata   = mem_pipe_mem_read ? w_load_data : mem_pipe_alu_result;
    assign mem_rd_write = w_mem_valid & mem_pipe_rd_write;
    assign mem_rd_addr  = mem_pipe_rd_addr;
    assign mem_rd_wdata = w_rd_wdata;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_wb_valid        <= 1'b0;
            r_wb_pc           <= '0;
            r_wb_instruction  <= '0;
            r_wb_rd_write     <= 1'b0;
            r_wb_rd_addr      <= '0;
            r_wb_rd_wdata     <= '0;
            r_wb_exc_load_mis <= 1'b0;
        end else begin
            if (wb_pipe_flush) begin
                r_wb_valid <= 1'b0;
            end else if (wb_pipe_ready) begin
                r_wb_valid <= w_mem_valid & w_mem_done;
            end
            if (wb_pipe_ready) begin
                r_wb_pc           <= mem_pipe_pc;
                r_wb_instruction  <= mem_pipe_instruction;
                r_wb_rd_write     <= mem_rd_write & ~w_misalign;
                r_wb_rd_addr      <= mem_pipe_rd_addr;
                r_wb_rd_wdata     <= w_rd_wdata;
                r_wb_exc_load_mis <= w_mem_valid & w_misalign;
            end
        end
    end

    assign wb_pipe_valid        = r_wb_valid;
    assign wb_pipe_pc           = r_wb_pc;
    assign wb_pipe_instruction  = r_wb_instruction;
    assign wb_pipe_rd_write     = r_wb_rd_write;
    assign wb_pipe_rd_addr      = r_wb_rd_addr;
    assign wb_pipe_rd_wdata     = r_wb_rd_wdata;
    assign wb_pipe_exc_load_mis = r_wb_exc_load_mis;

endmodule

// File: tb/tb_mem_stage.sv
// Directed and randomized bench for mem_stage; load results come from an arithmetic reference of the alignment rules.
// Inputs change on the falling edge; outputs are sampled 1 ns later, well away from the rising edge.

module tb_mem_stage;

    localparam logic [2:0] OP_B = 3'b001;
    localparam logic [2:0] OP_H = 3'b010;
    localparam logic [2:0] OP_W = 3'b100;
`ifdef MEM_MISALIGN_CHECK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_b;
    logic        mem_pipe_valid;
    logic [31:0] mem_pipe_pc;
    logic [31:0] mem_pipe_instruction;
    logic [2:0]  mem_pipe_mem_opcode;
    logic        mem_pipe_mem_read;
    logic        mem_pipe_unsign;
    logic        mem_pipe_rd_write;
    logic [4:0]  mem_pipe_rd_addr;
    logic [31:0] mem_pipe_alu_result;
    logic        mem_pipe_ready;
    logic        mem_pipe_flush;
    logic        dram_data_ok;
    logic [31:0] dram_rdata;
    logic        wb_pipe_ready;
    logic        wb_pipe_flush;
    logic        wb_pipe_valid;
    logic [31:0] wb_pipe_pc;
    logic [31:0] wb_pipe_instruction;
    logic        wb_pipe_rd_write;
    logic [4:0]  wb_pipe_rd_addr;
    logic [31:0] wb_pipe_rd_wdata;
    logic        wb_pipe_exc_load_mis;
    logic        mem_rd_write;
    logic [4:0]  mem_rd_addr;
    logic [31:0] mem_rd_wdata;
    logic        mem_load_pending;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    mem_stage dut (
        .clk                  (clk),
        .rst_b                (rst_b),
        .mem_pipe_valid       (mem_pipe_valid),
        .mem_pipe_pc          (mem_pipe_pc),
        .mem_pipe_instruction (mem_pipe_instruction),
        .mem_pipe_mem_opcode  (mem_pipe_mem_opcode),
        .mem_pipe_mem_read    (mem_pipe_mem_read),
        .mem_pipe_unsign      (mem_pipe_unsign),
        .mem_pipe_rd_write    (mem_pipe_rd_write),
        .mem_pipe_rd_addr     (mem_pipe_rd_addr),
        .mem_pipe_alu_result  (mem_pipe_alu_result),
        .mem_pipe_ready       (mem_pipe_ready),
        .mem_pipe_flush       (mem_pipe_flush),
        .dram_data_ok         (dram_data_ok),
        .dram_rdata           (dram_rdata),
        .wb_pipe_ready        (wb_pipe_ready),
        .wb_pipe_flush        (wb_pipe_flush),
        .wb_pipe_valid        (wb_pipe_valid),
        .wb_pipe_pc           (wb_pipe_pc),
        .wb_pipe_instruction  (wb_pipe_instruction),
        .wb_pipe_rd_write     (wb_pipe_rd_write),
        .wb_pipe_rd_addr      (wb_pipe_rd_addr),
        .wb_pipe_rd_wdata     (wb_pipe_rd_wdata),
        .wb_pipe_exc_load_mis (wb_pipe_exc_load_mis),
        .mem_rd_write         (mem_rd_write),
        .mem_rd_addr          (mem_rd_addr),
        .mem_rd_wdata         (mem_rd_wdata),
        .mem_load_pending     (mem_load_pending),
        .o_dbg_state          (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before 500000 ns");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference alignment: shift the addressed lane down, mask, then extend.
    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic uns,
                                             input logic [1:0] a, input logic [31:0] w);
        logic [31:0] v;
        if (op == OP_W) return w;
        if (op == OP_B) begin
            v = (w >> (8 * int'(a))) & 32'h0000_00FF;
            if (!uns && v[7]) v = v | 32'hFFFF_FF00;
        end else begin
            v = (w >> (16 * int'(a[1]))) & 32'h0000_FFFF;
            if (!uns && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    task automatic drive_idle();
        mem_pipe_valid       = 1'b0;
        mem_pipe_pc          = $urandom;
        mem_pipe_instruction = $urandom;
        mem_pipe_mem_opcode  = OP_W;
        mem_pipe_mem_read    = 1'b0;
        mem_pipe_unsign      = 1'b0;
        mem_pipe_rd_write    = 1'b0;
        mem_pipe_rd_addr     = '0;
        mem_pipe_alu_result  = $urandom;
        dram_data_ok         = 1'b0;
        dram_rdata           = $urandom;
        wb_pipe_ready        = 1'b1;
        wb_pipe_flush        = 1'b0;
    endtask

    // One instruction through MEM: response after lat cycles, WB stalled for stall cycles from then on.
    task automatic do_op(input logic ld, input logic [2:0] op, input logic uns,
                         input logic [31:0] addr, input logic [31:0] rdata,
                         input int lat, input int stall, input logic [4:0] rd,
                         input logic [31:0] exp_wdata);
        logic [31:0] pc;
        logic [31:0] ins;
        logic        mis;
        pc  = $urandom;
        ins = $urandom;
        mis = MIS_EN && ld && ((op == OP_H && addr[0]) || (op == OP_W && addr[1:0] != 2'd0));
        for (int c = 0; c <= lat + stall; c++) begin
            @(negedge clk);
            mem_pipe_valid       = 1'b1;
            mem_pipe_pc          = pc;
            mem_pipe_instruction = ins;
            mem_pipe_mem_opcode  = op;
            mem_pipe_mem_read    = ld;
            mem_pipe_unsign      = uns;
            mem_pipe_rd_write    = 1'b1;
            mem_pipe_rd_addr     = rd;
            mem_pipe_alu_result  = addr;
            dram_data_ok         = ld && (c == lat);
            dram_rdata           = (ld && c == lat) ? rdata : $urandom;
            wb_pipe_ready        = !(c >= lat && c < lat + stall);
            #1;
            check("load_pending", 32'(mem_load_pending), 32'(ld && c < lat));
            check("pipe_ready", 32'(mem_pipe_ready), 32'(c == lat + stall));
            if (c == lat + stall) begin
                check("fwd_wdata", mem_rd_wdata, exp_wdata);
                check("fwd_rd_write", 32'(mem_rd_write), 32'd1);
            end
        end
        @(negedge clk);
        drive_idle();
        #1;
        check("wb_valid", 32'(wb_pipe_valid), 32'd1);
        check("wb_rd_wdata", wb_pipe_rd_wdata, exp_wdata);
        check("wb_rd_addr", 32'(wb_pipe_rd_addr), 32'(rd));
        check("wb_pc", wb_pipe_pc, pc);
        check("wb_rd_write", 32'(wb_pipe_rd_write), 32'(!mis));
        check("wb_exc_load_mis", 32'(wb_pipe_exc_load_mis), 32'(mis));
        @(negedge clk);
        #1;
        check("wb_valid_once", 32'(wb_pipe_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] rdata_b;
        logic [31:0] addr;
        logic [31:0] rdata;
        logic [2:0]  op;
        logic        ld;
        logic        uns;
        int          lat;
        int          stall;

        drive_idle();
        rst_b = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_wb_valid", 32'(wb_pipe_valid), 32'd0);
        check("rst_wb_rd_wdata", wb_pipe_rd_wdata, 32'd0);
        check("rst_wb_exc", 32'(wb_pipe_exc_load_mis), 32'd0);
        check("rst_pending", 32'(mem_load_pending), 32'd0);
        check("rst_ready", 32'(mem_pipe_ready), 32'd1);
        @(negedge clk);
        rst_b = 1'b1;

        // ALU result passes straight through.
        do_op(1'b0, OP_W, 1'b0, 32'h0000_1234, 32'h0, 0, 0, 5'd5, 32'h0000_1234);
        // Zero-wait loads with sign/zero extension.
        do_op(1'b1, OP_B, 1'b0, 32'h0000_0103, 32'h80FF_0000, 0, 0, 5'd6, 32'hFFFF_FF80);
        do_op(1'b1, OP_B, 1'b1, 32'h0000_0103, 32'h80FF_0000, 0, 0, 5'd7, 32'h0000_0080);
        do_op(1'b1, OP_H, 1'b0, 32'h0000_0102, 32'h80FF_0000, 0, 0, 5'd8, 32'hFFFF_80FF);
        // Delayed response, then a response parked while WB stalls.
        do_op(1'b1, OP_W, 1'b0, 32'h0000_1000, 32'hCAFE_F00D, 3, 0, 5'd9, 32'hCAFE_F00D);
        do_op(1'b1, OP_W, 1'b0, 32'h0000_2000, 32'h1357_9BDF, 1, 2, 5'd10, 32'h1357_9BDF);
        // Misaligned word load.
        do_op(1'b1, OP_W, 1'b0, 32'h0000_0302, 32'hA5A5_5A5A, 0, 0, 5'd11, 32'hA5A5_5A5A);

        // A load flushed while waiting: its late response must be discarded.
        @(negedge clk);
        mem_pipe_valid      = 1'b1;
        mem_pipe_mem_read   = 1'b1;
        mem_pipe_mem_opcode = OP_W;
        mem_pipe_rd_write   = 1'b1;
        mem_pipe_rd_addr    = 5'd12;
        mem_pipe_alu_result = 32'h0000_4000;
        #1;
        check("flush_a_pending", 32'(mem_load_pending), 32'd1);
        @(negedge clk);
        wb_pipe_flush = 1'b1;
        #1;
        check("flush_out", 32'(mem_pipe_flush), 32'd1);
        check("flush_fwd_write", 32'(mem_rd_write), 32'd0);
        @(negedge clk);
        rdata_b = $urandom;
        wb_pipe_flush       = 1'b0;
        mem_pipe_rd_addr    = 5'd13;
        mem_pipe_alu_result = 32'h0000_5001;
        mem_pipe_mem_opcode = OP_B;
        mem_pipe_unsign     = 1'b0;
        dram_data_ok        = 1'b1;
        dram_rdata          = ~rdata_b;
        #1;
        check("drop_pending", 32'(mem_load_pending), 32'd1);
        check("drop_ready", 32'(mem_pipe_ready), 32'd0);
        check("drop_wb_valid", 32'(wb_pipe_valid), 32'd0);
        @(negedge clk);
        dram_rdata = rdata_b;
        #1;
        check("second_pending", 32'(mem_load_pending), 32'd0);
        check("second_ready", 32'(mem_pipe_ready), 32'd1);
        check("second_fwd", mem_rd_wdata, ref_load(OP_B, 1'b0, 2'd1, rdata_b));
        @(negedge clk);
        drive_idle();
        #1;
        check("second_wb_valid", 32'(wb_pipe_valid), 32'd1);
        check("second_wb_wdata", wb_pipe_rd_wdata, ref_load(OP_B, 1'b0, 2'd1, rdata_b));
        check("second_wb_addr", 32'(wb_pipe_rd_addr), 32'd13);
        @(negedge clk);
        #1;
        check("second_once", 32'(wb_pipe_valid), 32'd0);

        // Randomized mix of ALU ops and loads with random latency and WB back-pressure.
        for (int i = 0; i < 60; i++) begin
            ld    = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 2))
                0:       op = OP_B;
                1:       op = OP_H;
                default: op = OP_W;
            endcase
            uns   = 1'($urandom_range(0, 1));
            addr  = $urandom;
            rdata = $urandom;
            lat   = ld ? int'($urandom_range(0, 3)) : 0;
            stall = $urandom_range(0, 2);
            do_op(ld, op, uns, addr, rdata, lat, stall, 5'($urandom_range(0, 31)),
                  ld ? ref_load(op, uns, addr[1:0], rdata) : addr);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
